// File: rtl/axi_slave_wr_arbiter.sv
// rtl/axi_slave_wr_arbiter.sv - per-slave AXI write-channel arbiter (AW/W grant, ID prefix, B return routing)
//
// Optional build macro: AXI_WR_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin; the round-robin pointer is then held at 0.
//
// Ports:
//   BUS_CLK, BUS_RSTN            clock, synchronous active-low reset
//   M_WR_ADDR_* [N-1:0]          per-master AW channel (ID/ADDR/LEN/BURST/VALID in, READY out)
//   M_WR_DATA_* [N-1:0]          per-master W channel (DATA/STRB/LAST/VALID in, READY out)
//   M_WR_BACK_* [N-1:0]          per-master B channel (ID/RESP/VALID out, READY in)
//   S_WR_ADDR_*                  slave AW channel, ID = {grant index, master ID}
//   S_WR_DATA_*                  slave W channel, routed from the granted master
//   S_WR_BACK_*                  slave B channel, routed by the ID prefix
//   GRANT                        current/last granted master index

module axi_slave_wr_arbiter #(
    parameter int          M_ID       = 2,
    parameter int          M_WIDTH    = 2,
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter logic [31:0] END_ADDR   = 32'h0FFF_FFFF,
    localparam int         N          = 1 << M_WIDTH
) (
    input  logic                        BUS_CLK,
    input  logic                        BUS_RSTN,

    input  logic [N-1:0][M_ID-1:0]      M_WR_ADDR_ID,
    input  logic [N-1:0][31:0]          M_WR_ADDR,
    input  logic [N-1:0][7:0]           M_WR_ADDR_LEN,
    input  logic [N-1:0][1:0]           M_WR_ADDR_BURST,
    input  logic [N-1:0]                M_WR_ADDR_VALID,
    output logic [N-1:0]                M_WR_ADDR_READY,

    input  logic [N-1:0][31:0]          M_WR_DATA,
    input  logic [N-1:0][3:0]           M_WR_STRB,
    input  logic [N-1:0]                M_WR_DATA_LAST,
    input  logic [N-1:0]                M_WR_DATA_VALID,
    output logic [N-1:0]                M_WR_DATA_READY,

    output logic [N-1:0][M_ID-1:0]      M_WR_BACK_ID,
    output logic [N-1:0][1:0]           M_WR_BACK_RESP,
    output logic [N-1:0]                M_WR_BACK_VALID,
    input  logic [N-1:0]                M_WR_BACK_READY,

    output logic [M_WIDTH+M_ID-1:0]     S_WR_ADDR_ID,
    output logic [31:0]                 S_WR_ADDR,
    output logic [7:0]                  S_WR_ADDR_LEN,
    output logic [1:0]                  S_WR_ADDR_BURST,
    output logic                        S_WR_ADDR_VALID,
    input  logic                        S_WR_ADDR_READY,

    output logic [31:0]                 S_WR_DATA,
    output logic [3:0]                  S_WR_STRB,
    output logic                        S_WR_DATA_LAST,
    output logic                        S_WR_DATA_VALID,
    input  logic                        S_WR_DATA_READY,

    input  logic [M_WIDTH+M_ID-1:0]     S_WR_BACK_ID,
    input  logic [1:0]                  S_WR_BACK_RESP,
    input  logic                        S_WR_BACK_VALID,
    output logic                        S_WR_BACK_READY,

    output logic [M_WIDTH-1:0]          GRANT
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_AW_W    = 2'd1,
        ST_W_ONLY  = 2'd2,
        ST_AW_ONLY = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [M_WIDTH-1:0]  grant_q;
    logic [M_WIDTH-1:0]  grant_next;
    logic [M_WIDTH-1:0]  rr;
    logic [M_WIDTH-1:0]  rr_next;
    logic [M_WIDTH-1:0]  pick;
    logic                found;
    logic                load_aw;
    logic [N-1:0]        req;

    logic [M_ID-1:0]     aw_id_q;
    logic [31:0]         aw_addr_q;
    logic [7:0]          aw_len_q;
    logic [1:0]          aw_burst_q;

    logic                aw_phase;
    logic                w_phase;
    logic                aw_hs;
    logic                w_last_hs;

`ifndef AXI_WR_ARB_FIXED_PRIO_EN
    logic [M_WIDTH-1:0]  idx;
`endif

    // Window decode as one unsigned compare: addresses below START_ADDR wrap
    // to a large offset and fall outside the span.
    for (genvar i = 0; i < N; i++) begin : g_req
        assign req[i] = M_WR_ADDR_VALID[i] &&
                        ((M_WR_ADDR[i] - START_ADDR) <= (END_ADDR - START_ADDR));
    end

    assign aw_phase  = (state == ST_AW_W) || (state == ST_AW_ONLY);
    assign w_phase   = (state == ST_AW_W) || (state == ST_W_ONLY);
    assign aw_hs     = aw_phase && S_WR_ADDR_READY;
    assign w_last_hs = w_phase && M_WR_DATA_VALID[grant_q] &&
                       M_WR_DATA_LAST[grant_q] && S_WR_DATA_READY;

    // Next-state, grant selection and pointer update.
    always_comb begin
        state_next = state;
        grant_next = grant_q;
        rr_next    = rr;
        load_aw    = 1'b0;
        found      = 1'b0;
        pick       = '0;
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                pick = M_WIDTH'(k);
            end
        end
        found = |req;
`else
        idx = rr;
        for (int k = 0; k < N; k++) begin
            idx = rr + M_WIDTH'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
`endif

        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_next = ST_AW_W;
                    grant_next = pick;
                    load_aw    = 1'b1;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
                    rr_next    = pick + 1'b1;
`endif
                end
            end
            ST_AW_W: begin
                if (aw_hs && w_last_hs) begin
                    state_next = ST_IDLE;
                end else if (aw_hs) begin
                    state_next = ST_W_ONLY;
                end else if (w_last_hs) begin
                    state_next = ST_AW_ONLY;
                end
            end
            ST_W_ONLY: begin
                if (w_last_hs) begin
                    state_next = ST_IDLE;
                end
            end
            ST_AW_ONLY: begin
                if (aw_hs) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RSTN) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            rr         <= '0;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_burst_q <= '0;
        end else begin
            state   <= state_next;
            grant_q <= grant_next;
            rr      <= rr_next;
            if (load_aw) begin
                aw_id_q    <= M_WR_ADDR_ID[pick];
                aw_addr_q  <= M_WR_ADDR[pick];
                aw_len_q   <= M_WR_ADDR_LEN[pick];
                aw_burst_q <= M_WR_ADDR_BURST[pick];
            end
        end
    end

    // AW comes from the registered payload; master READY is a pass-through of
    // slave READY so the master retires its AW on the slave handshake cycle.
    always_comb begin
        M_WR_ADDR_READY = '0;
        if (aw_phase) begin
            M_WR_ADDR_READY[grant_q] = S_WR_ADDR_READY;
        end
        S_WR_ADDR_VALID = aw_phase;
        S_WR_ADDR_ID    = {grant_q, aw_id_q};
        S_WR_ADDR       = aw_addr_q;
        S_WR_ADDR_LEN   = aw_len_q;
        S_WR_ADDR_BURST = aw_burst_q;
    end

    // W is a combinational mux from the granted master while W is still open.
    always_comb begin
        M_WR_DATA_READY = '0;
        if (w_phase) begin
            M_WR_DATA_READY[grant_q] = S_WR_DATA_READY;
        end
        S_WR_DATA       = M_WR_DATA[grant_q];
        S_WR_STRB       = M_WR_STRB[grant_q];
        S_WR_DATA_LAST  = w_phase && M_WR_DATA_LAST[grant_q];
        S_WR_DATA_VALID = w_phase && M_WR_DATA_VALID[grant_q];
    end

    // B return is stateless: the ID prefix selects the destination master.
    always_comb begin
        M_WR_BACK_VALID = '0;
        M_WR_BACK_VALID[S_WR_BACK_ID[M_WIDTH+M_ID-1:M_ID]] = S_WR_BACK_VALID;
        for (int i = 0; i < N; i++) begin
            M_WR_BACK_ID[i]   = S_WR_BACK_ID[M_ID-1:0];
            M_WR_BACK_RESP[i] = S_WR_BACK_RESP;
        end
        S_WR_BACK_READY = M_WR_BACK_READY[S_WR_BACK_ID[M_WIDTH+M_ID-1:M_ID]];
    end

    assign GRANT = grant_q;

endmodule

// File: tb/tb_axi_slave_wr_arbiter.sv
// tb/tb_axi_slave_wr_arbiter.sv - directed self-checking bench for axi_slave_wr_arbiter

module tb_axi_slave_wr_arbiter;

    logic              BUS_CLK;
    logic              BUS_RSTN;
    logic [3:0][1:0]   M_WR_ADDR_ID;
    logic [3:0][31:0]  M_WR_ADDR;
    logic [3:0][7:0]   M_WR_ADDR_LEN;
    logic [3:0][1:0]   M_WR_ADDR_BURST;
    logic [3:0]        M_WR_ADDR_VALID;
    logic [3:0]        M_WR_ADDR_READY;
    logic [3:0][31:0]  M_WR_DATA;
    logic [3:0][3:0]   M_WR_STRB;
    logic [3:0]        M_WR_DATA_LAST;
    logic [3:0]        M_WR_DATA_VALID;
    logic [3:0]        M_WR_DATA_READY;
    logic [3:0][1:0]   M_WR_BACK_ID;
    logic [3:0][1:0]   M_WR_BACK_RESP;
    logic [3:0]        M_WR_BACK_VALID;
    logic [3:0]        M_WR_BACK_READY;
    logic [3:0]        S_WR_ADDR_ID;
    logic [31:0]       S_WR_ADDR;
    logic [7:0]        S_WR_ADDR_LEN;
    logic [1:0]        S_WR_ADDR_BURST;
    logic              S_WR_ADDR_VALID;
    logic              S_WR_ADDR_READY;
    logic [31:0]       S_WR_DATA;
    logic [3:0]        S_WR_STRB;
    logic              S_WR_DATA_LAST;
    logic              S_WR_DATA_VALID;
    logic              S_WR_DATA_READY;
    logic [3:0]        S_WR_BACK_ID;
    logic [1:0]        S_WR_BACK_RESP;
    logic              S_WR_BACK_VALID;
    logic              S_WR_BACK_READY;
    logic [1:0]        GRANT;

    int n_tests;
    int n_fail;

    axi_slave_wr_arbiter dut (
        .BUS_CLK         (BUS_CLK),
        .BUS_RSTN        (BUS_RSTN),
        .M_WR_ADDR_ID    (M_WR_ADDR_ID),
        .M_WR_ADDR       (M_WR_ADDR),
        .M_WR_ADDR_LEN   (M_WR_ADDR_LEN),
        .M_WR_ADDR_BURST (M_WR_ADDR_BURST),
        .M_WR_ADDR_VALID (M_WR_ADDR_VALID),
        .M_WR_ADDR_READY (M_WR_ADDR_READY),
        .M_WR_DATA       (M_WR_DATA),
        .M_WR_STRB       (M_WR_STRB),
        .M_WR_DATA_LAST  (M_WR_DATA_LAST),
        .M_WR_DATA_VALID (M_WR_DATA_VALID),
        .M_WR_DATA_READY (M_WR_DATA_READY),
        .M_WR_BACK_ID    (M_WR_BACK_ID),
        .M_WR_BACK_RESP  (M_WR_BACK_RESP),
        .M_WR_BACK_VALID (M_WR_BACK_VALID),
        .M_WR_BACK_READY (M_WR_BACK_READY),
        .S_WR_ADDR_ID    (S_WR_ADDR_ID),
        .S_WR_ADDR       (S_WR_ADDR),
        .S_WR_ADDR_LEN   (S_WR_ADDR_LEN),
        .S_WR_ADDR_BURST (S_WR_ADDR_BURST),
        .S_WR_ADDR_VALID (S_WR_ADDR_VALID),
        .S_WR_ADDR_READY (S_WR_ADDR_READY),
        .S_WR_DATA       (S_WR_DATA),
        .S_WR_STRB       (S_WR_STRB),
        .S_WR_DATA_LAST  (S_WR_DATA_LAST),
        .S_WR_DATA_VALID (S_WR_DATA_VALID),
        .S_WR_DATA_READY (S_WR_DATA_READY),
        .S_WR_BACK_ID    (S_WR_BACK_ID),
        .S_WR_BACK_RESP  (S_WR_BACK_RESP),
        .S_WR_BACK_VALID (S_WR_BACK_VALID),
        .S_WR_BACK_READY (S_WR_BACK_READY),
        .GRANT           (GRANT)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        M_WR_ADDR_ID    = '0;
        M_WR_ADDR       = '0;
        M_WR_ADDR_LEN   = '0;
        M_WR_ADDR_BURST = '0;
        M_WR_ADDR_VALID = '0;
        M_WR_DATA       = '0;
        M_WR_STRB       = '0;
        M_WR_DATA_LAST  = '0;
        M_WR_DATA_VALID = '0;
        M_WR_BACK_READY = '0;
        S_WR_ADDR_READY = 1'b0;
        S_WR_DATA_READY = 1'b0;
        S_WR_BACK_ID    = '0;
        S_WR_BACK_RESP  = '0;
        S_WR_BACK_VALID = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge BUS_CLK);
        BUS_RSTN = 1'b0;
        clear_inputs();
        @(negedge BUS_CLK);
        BUS_RSTN = 1'b1;
    endtask

    logic [1:0] exp_g [5];
    logic [1:0] e;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        BUS_RSTN = 1'b0;
        clear_inputs();
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
        exp_g = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif

        // Reset state
        do_reset();
        #1;
        check("rst_aw_valid", 64'(S_WR_ADDR_VALID), 64'd0);
        check("rst_w_valid",  64'(S_WR_DATA_VALID), 64'd0);
        check("rst_grant",    64'(GRANT),           64'd0);
        check("rst_aw_ready", 64'(M_WR_ADDR_READY), 64'd0);
        check("rst_w_ready",  64'(M_WR_DATA_READY), 64'd0);

        // Single master 1, LEN=3 burst
        @(negedge BUS_CLK);
        M_WR_ADDR_VALID[1] = 1'b1;
        M_WR_ADDR[1]       = 32'h0000_0100;
        M_WR_ADDR_ID[1]    = 2'b10;
        M_WR_ADDR_LEN[1]   = 8'd3;
        M_WR_ADDR_BURST[1] = 2'b01;
        S_WR_ADDR_READY    = 1'b1;
        #1;
        check("t1_idle_noready", 64'(M_WR_ADDR_READY), 64'd0);
        @(negedge BUS_CLK);
        #1;
        check("t1_aw_valid",  64'(S_WR_ADDR_VALID), 64'd1);
        check("t1_aw_id",     64'(S_WR_ADDR_ID),    64'h6);
        check("t1_aw_addr",   64'(S_WR_ADDR),       64'h100);
        check("t1_aw_len",    64'(S_WR_ADDR_LEN),   64'd3);
        check("t1_aw_burst",  64'(S_WR_ADDR_BURST), 64'd1);
        check("t1_grant",     64'(GRANT),           64'd1);
        check("t1_aw_ready",  64'(M_WR_ADDR_READY), 64'h2);
        for (int b = 0; b < 4; b++) begin
            @(negedge BUS_CLK);
            M_WR_ADDR_VALID[1] = 1'b0;
            S_WR_ADDR_READY    = 1'b0;
            M_WR_DATA_VALID[1] = 1'b1;
            M_WR_DATA[1]       = 32'hA000_0000 + 32'(b);
            M_WR_STRB[1]       = 4'hF;
            M_WR_DATA_LAST[1]  = (b == 3);
            S_WR_DATA_READY    = 1'b1;
            #1;
            check("t1_w_data",   64'(S_WR_DATA),       64'hA000_0000 + 64'(b));
            check("t1_w_last",   64'(S_WR_DATA_LAST),  (b == 3) ? 64'd1 : 64'd0);
            check("t1_w_valid",  64'(S_WR_DATA_VALID), 64'd1);
            check("t1_w_ready",  64'(M_WR_DATA_READY), 64'h2);
            check("t1_aw_done",  64'(S_WR_ADDR_VALID), 64'd0);
        end
        @(negedge BUS_CLK);
        M_WR_DATA_VALID[1] = 1'b0;
        #1;
        check("t1_idle_wvalid", 64'(S_WR_DATA_VALID), 64'd0);
        check("t1_idle_wready", 64'(M_WR_DATA_READY), 64'd0);

        // Four masters requesting continuously, zero-wait slave
        do_reset();
        @(negedge BUS_CLK);
        for (int i = 0; i < 4; i++) begin
            M_WR_ADDR_VALID[i] = 1'b1;
            M_WR_ADDR[i]       = 32'h0000_1000 * 32'(i);
            M_WR_ADDR_ID[i]    = 2'(i);
            M_WR_DATA_VALID[i] = 1'b1;
            M_WR_DATA_LAST[i]  = 1'b1;
            M_WR_DATA[i]       = 32'(i);
        end
        S_WR_ADDR_READY = 1'b1;
        S_WR_DATA_READY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e = exp_g[k];
            @(negedge BUS_CLK);
            #1;
            check("t2_grant",    64'(GRANT),           64'(e));
            check("t2_aw_valid", 64'(S_WR_ADDR_VALID), 64'd1);
            check("t2_aw_id",    64'(S_WR_ADDR_ID),    64'({e, e}));
            check("t2_w_ready",  64'(M_WR_DATA_READY), 64'(4'b0001 << e));
            @(negedge BUS_CLK);
            #1;
            check("t2_idle_gap", 64'(S_WR_ADDR_VALID), 64'd0);
        end

        // Out-of-window master 2, then the inclusive upper boundary
        do_reset();
        @(negedge BUS_CLK);
        M_WR_ADDR_VALID[2] = 1'b1;
        M_WR_ADDR[2]       = 32'h1000_0000;
        S_WR_ADDR_READY    = 1'b1;
        S_WR_DATA_READY    = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge BUS_CLK);
            #1;
            check("t3_oow_ready", 64'(M_WR_ADDR_READY), 64'd0);
            check("t3_oow_valid", 64'(S_WR_ADDR_VALID), 64'd0);
        end
        M_WR_ADDR[2] = 32'h0FFF_FFFF;
        @(negedge BUS_CLK);
        #1;
        check("t3_edge_valid", 64'(S_WR_ADDR_VALID), 64'd1);
        check("t3_edge_grant", 64'(GRANT),           64'd2);

        // W LAST accepted before AW (AW_ONLY path)
        do_reset();
        @(negedge BUS_CLK);
        M_WR_ADDR_VALID[0] = 1'b1;
        M_WR_ADDR[0]       = 32'h0000_0200;
        M_WR_ADDR_ID[0]    = 2'b01;
        M_WR_DATA_VALID[0] = 1'b1;
        M_WR_DATA_LAST[0]  = 1'b1;
        M_WR_DATA[0]       = 32'hCAFE_F00D;
        M_WR_STRB[0]       = 4'hF;
        S_WR_DATA_READY    = 1'b1;
        @(negedge BUS_CLK);
        #1;
        check("t4_w_data",   64'(S_WR_DATA),       64'hCAFE_F00D);
        check("t4_w_last",   64'(S_WR_DATA_LAST),  64'd1);
        check("t4_w_ready",  64'(M_WR_DATA_READY), 64'h1);
        check("t4_aw_ready", 64'(M_WR_ADDR_READY), 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge BUS_CLK);
            M_WR_DATA_VALID[0] = 1'b0;
            #1;
            check("t4_awo_valid",  64'(S_WR_ADDR_VALID), 64'd1);
            check("t4_awo_addr",   64'(S_WR_ADDR),       64'h200);
            check("t4_awo_wvalid", 64'(S_WR_DATA_VALID), 64'd0);
            check("t4_awo_wready", 64'(M_WR_DATA_READY), 64'd0);
        end
        @(negedge BUS_CLK);
        S_WR_ADDR_READY = 1'b1;
        #1;
        check("t4_aw_hs_ready", 64'(M_WR_ADDR_READY), 64'h1);
        check("t4_aw_hs_id",    64'(S_WR_ADDR_ID),    64'h1);
        @(negedge BUS_CLK);
        M_WR_ADDR_VALID[0] = 1'b0;
        S_WR_ADDR_READY    = 1'b0;
        #1;
        check("t4_idle_valid", 64'(S_WR_ADDR_VALID), 64'd0);

        // B response routing
        @(negedge BUS_CLK);
        S_WR_BACK_ID    = 4'b1101;
        S_WR_BACK_RESP  = 2'b00;
        S_WR_BACK_VALID = 1'b1;
        M_WR_BACK_READY = 4'b0000;
        #1;
        check("t5_b_valid",  64'(M_WR_BACK_VALID), 64'h8);
        check("t5_b_id",     64'(M_WR_BACK_ID[3]), 64'h1);
        check("t5_b_ready0", 64'(S_WR_BACK_READY), 64'd0);
        @(negedge BUS_CLK);
        M_WR_BACK_READY = 4'b0111;
        #1;
        check("t5_b_ready1", 64'(S_WR_BACK_READY), 64'd0);
        check("t5_b_valid1", 64'(M_WR_BACK_VALID), 64'h8);
        @(negedge BUS_CLK);
        M_WR_BACK_READY = 4'b1000;
        #1;
        check("t5_b_ready2", 64'(S_WR_BACK_READY), 64'd1);
        @(negedge BUS_CLK);
        S_WR_BACK_ID    = 4'b0010;
        S_WR_BACK_RESP  = 2'b10;
        M_WR_BACK_READY = 4'b0001;
        #1;
        check("t5_b0_valid", 64'(M_WR_BACK_VALID),   64'h1);
        check("t5_b0_id",    64'(M_WR_BACK_ID[0]),   64'h2);
        check("t5_b0_resp",  64'(M_WR_BACK_RESP[0]), 64'h2);
        check("t5_b0_ready", 64'(S_WR_BACK_READY),   64'd1);
        @(negedge BUS_CLK);
        S_WR_BACK_VALID = 1'b0;
        #1;
        check("t5_b_idle",   64'(M_WR_BACK_VALID), 64'd0);

        // Reset during W_ONLY
        do_reset();
        @(negedge BUS_CLK);
        M_WR_ADDR_VALID[3] = 1'b1;
        M_WR_ADDR[3]       = 32'h0000_0300;
        M_WR_ADDR_ID[3]    = 2'b11;
        M_WR_ADDR_LEN[3]   = 8'd1;
        S_WR_ADDR_READY    = 1'b1;
        @(negedge BUS_CLK);
        #1;
        check("t6_grant", 64'(GRANT), 64'd3);
        @(negedge BUS_CLK);
        M_WR_ADDR_VALID[3] = 1'b0;
        S_WR_ADDR_READY    = 1'b0;
        M_WR_DATA_VALID[3] = 1'b1;
        M_WR_DATA[3]       = 32'h1234_5678;
        #1;
        check("t6_wonly_wvalid", 64'(S_WR_DATA_VALID), 64'd1);
        check("t6_wonly_aw",     64'(S_WR_ADDR_VALID), 64'd0);
        BUS_RSTN = 1'b0;
        @(negedge BUS_CLK);
        BUS_RSTN        = 1'b1;
        S_WR_ADDR_READY = 1'b1;
        S_WR_DATA_READY = 1'b1;
        #1;
        check("t6_rst_aw_valid", 64'(S_WR_ADDR_VALID), 64'd0);
        check("t6_rst_w_valid",  64'(S_WR_DATA_VALID), 64'd0);
        check("t6_rst_w_ready",  64'(M_WR_DATA_READY), 64'd0);
        check("t6_rst_aw_ready", 64'(M_WR_ADDR_READY), 64'd0);
        check("t6_rst_grant",    64'(GRANT),           64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
